// File: rtl/fetch_engine.sv
// fetch_engine: front-end fetch stage upstream of the fetch buffer.
//
// Issues 16-byte-aligned sequential I-cache requests, tracks outstanding
// requests, collects in-order responses into a QDEPTH-entry section queue and
// presents the queue head to the fetch buffer. Redirects re-steer the fetch
// PC, flush the queue and discard responses of requests already in flight.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset (qualified by clkEn)
//   clkEn               global clock enable; all state holds when low
//   redirect_valid/_pc  redirect request and byte target
//   icache_req_*        request valid/ready handshake, 16B-aligned address
//   icache_resp_*       in-order response, always accepted
//   section_*           queue head: valid/ready, data, pc, first-byte offset
//
// Optional build macro FETCH_ENGINE_PERF_EN adds perf_req_cnt, perf_drop_cnt
// and perf_stall_cnt saturating 32-bit counters.
module fetch_engine #(
    parameter int               WIDTH    = 64,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               QDEPTH   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clkEn,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             icache_req_valid,
    input  logic             icache_req_ready,
    output logic [WIDTH-1:0] icache_req_addr,
    input  logic             icache_resp_valid,
    input  logic [127:0]     icache_resp_data,
    output logic             section_valid,
    input  logic             section_ready,
    output logic [127:0]     section_data,
    output logic [WIDTH-1:0] section_pc,
    output logic [3:0]       section_offset
`ifdef FETCH_ENGINE_PERF_EN
    ,
    output logic [31:0]      perf_req_cnt,
    output logic [31:0]      perf_drop_cnt,
    output logic [31:0]      perf_stall_cnt
`endif
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);

    typedef enum logic {RUN, DRAIN} state_e;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    state_e           state_q, state_d;
    logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]    outst_q, outst_d;
    logic [CW-1:0]    drop_q, drop_d;
    logic [3:0]       poff_q, poff_d;
    logic             req_hold_q;

    // section queue
    logic [127:0]     q_data_q [QDEPTH];
    logic [WIDTH-1:0] q_pc_q   [QDEPTH];
    logic [3:0]       q_off_q  [QDEPTH];
    logic [PW-1:0]    q_rd_q, q_rd_d, q_wr_q, q_wr_d;
    logic [CW-1:0]    q_cnt_q, q_cnt_d;

    // per-request pc FIFO; its occupancy is outst_q
    logic [WIDTH-1:0] pf_pc_q [QDEPTH];
    logic [PW-1:0]    pf_rd_q, pf_rd_d, pf_wr_q, pf_wr_d;

    logic          act, credit_ok, req_live, hs, resp, push, pop, discard;
    logic [CW:0]   total, drop_left;

    // act gates every state update: nothing moves without clkEn, reset wins.
    assign act       = clkEn && !rst;
    // Credit counts queued plus in-flight sections so every response has a slot.
    assign credit_ok = ({1'b0, outst_q} + {1'b0, q_cnt_q}) < (CW+1)'(QDEPTH);
    assign req_live  = (state_q == RUN) && !rst && !redirect_valid && credit_ok;
    assign hs        = act && req_live && icache_req_ready;
    assign resp      = act && icache_resp_valid;
    assign push      = resp && !redirect_valid && (state_q == RUN) && (outst_q != '0);
    assign pop       = act && !redirect_valid && section_valid && section_ready;

    // Responses still owed by the cache; drop_q is only nonzero in DRAIN and
    // outst_q is zero there, so the sum covers both states.
    assign total     = {1'b0, outst_q} + {1'b0, drop_q};
    assign discard   = resp && (total != '0) && (redirect_valid || state_q == DRAIN);
    assign drop_left = total - (CW+1)'(discard);

    // Valid is held across clkEn-low cycles, like every registered output.
    assign icache_req_valid = clkEn ? req_live : req_hold_q;
    assign icache_req_addr  = fetch_pc_q;

    assign section_valid  = (q_cnt_q != '0);
    assign section_data   = section_valid ? q_data_q[q_rd_q] : '0;
    assign section_pc     = section_valid ? q_pc_q[q_rd_q]   : '0;
    assign section_offset = section_valid ? q_off_q[q_rd_q]  : '0;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        poff_d     = poff_q;
        q_rd_d     = q_rd_q;
        q_wr_d     = q_wr_q;
        q_cnt_d    = q_cnt_q;
        pf_rd_d    = pf_rd_q;
        pf_wr_d    = pf_wr_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[WIDTH-1:4], 4'h0};
            poff_d     = redirect_pc[3:0];
            outst_d    = '0;
            drop_d     = drop_left[CW-1:0];
            state_d    = (drop_d != '0) ? DRAIN : RUN;
            q_rd_d     = '0;
            q_wr_d     = '0;
            q_cnt_d    = '0;
            pf_rd_d    = '0;
            pf_wr_d    = '0;
        end else begin
            if (state_q == DRAIN) begin
                if (resp && drop_q != '0) drop_d = drop_q - CW'(1);
                state_d = (drop_d == '0) ? RUN : DRAIN;
            end
            if (hs) begin
                fetch_pc_d = fetch_pc_q + WIDTH'(16);
                pf_wr_d    = nxt(pf_wr_q);
            end
            if (push) begin
                pf_rd_d = nxt(pf_rd_q);
                q_wr_d  = nxt(q_wr_q);
                poff_d  = 4'h0;
            end
            if (pop) q_rd_d = nxt(q_rd_q);
            outst_d = outst_q + CW'(hs) - CW'(push);
            q_cnt_d = q_cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (clkEn) begin
            if (rst) begin
                state_q    <= RUN;
                fetch_pc_q <= {RESET_PC[WIDTH-1:4], 4'h0};
                outst_q    <= '0;
                drop_q     <= '0;
                poff_q     <= RESET_PC[3:0];
                req_hold_q <= 1'b0;
                q_rd_q     <= '0;
                q_wr_q     <= '0;
                q_cnt_q    <= '0;
                pf_rd_q    <= '0;
                pf_wr_q    <= '0;
            end else begin
                state_q    <= state_d;
                fetch_pc_q <= fetch_pc_d;
                outst_q    <= outst_d;
                drop_q     <= drop_d;
                poff_q     <= poff_d;
                req_hold_q <= req_live;
                q_rd_q     <= q_rd_d;
                q_wr_q     <= q_wr_d;
                q_cnt_q    <= q_cnt_d;
                pf_rd_q    <= pf_rd_d;
                pf_wr_q    <= pf_wr_d;
            end
        end
    end

    // Storage needs no reset; readers are gated by count/occupancy.
    always_ff @(posedge clk) begin
        if (hs) pf_pc_q[pf_wr_q] <= fetch_pc_q;
        if (push) begin
            q_data_q[q_wr_q] <= icache_resp_data;
            q_pc_q[q_wr_q]   <= pf_pc_q[pf_rd_q];
            q_off_q[q_wr_q]  <= poff_q;
        end
    end

`ifdef FETCH_ENGINE_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
    endfunction

    logic [31:0] perf_req_q, perf_drop_q, perf_stall_q;

    always_ff @(posedge clk) begin
        if (clkEn) begin
            if (rst) begin
                perf_req_q   <= '0;
                perf_drop_q  <= '0;
                perf_stall_q <= '0;
            end else begin
                perf_req_q   <= sat_inc(perf_req_q, hs);
                perf_drop_q  <= sat_inc(perf_drop_q, discard);
                perf_stall_q <= sat_inc(perf_stall_q, section_valid && !section_ready);
            end
        end
    end

    assign perf_req_cnt   = perf_req_q;
    assign perf_drop_cnt  = perf_drop_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule
